pc_ctrl: RTL

Program-counter and branch-control unit for the 16-bit core; it is the consumer of the execute stage's branch outputs. Each cycle it takes the branch request (jump_en, 6-bit offset) and the branching instruction's address from EX, and drives the 7-bit fetch address to instruction memory. On a taken branch it redirects fetch and runs a flush sequence that kills wrong-path instructions in IF/ID and ID/EX. It also detects program end (branch-to-self or running off the top of memory) and halts fetch.

---
 rtl/pc_ctrl_pkg.sv | 13 +
 rtl/pc_ctrl_sat_cnt8.sv | 12 +
 rtl/pc_ctrl.sv | 54 +++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared widths, PC FSM state encodings and the branch target helper
package pc_ctrl_pkg;
  localparam int PC_W = 7;
  localparam int OFF_W = 6;
  typedef enum logic [1:0] {
    PC_RUN   = 2'd0,
    PC_FLUSH = 2'd1,
    PC_HALT  = 2'd2
  } pc_state_e;
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] base, input logic [OFF_W-1:0] off);
    return base + {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction
endpackage

// File: rtl/pc_ctrl_sat_cnt8.sv
// sat_cnt8: 8-bit event counter that sticks at 255
module sat_cnt8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] cnt
);
  // count events, holding at the top value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (inc && cnt != 8'hff) cnt <= cnt + 8'd1;
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: program counter with branch redirect, wrong-path flush and halt detection
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              FLUSH_CYCLES = 2,
  parameter logic [PC_W-1:0] PC_RESET     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jump_en_i,
  input  logic [OFF_W-1:0] jump_offset_i,
  input  logic [PC_W-1:0]  jump_base_i,
  input  logic             hold_i,
  output logic [PC_W-1:0]  inst_addr_o,
  output logic             inst_valid_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic [7:0]       branch_cnt_o
);
  pc_state_e       state;
  logic [1:0]      fcnt;
  logic [PC_W-1:0] pc, target;
  logic            take, adv, top;
  assign target = branch_target(jump_base_i, jump_offset_i);
  assign take = state == PC_RUN && jump_en_i;
  assign adv = (state == PC_FLUSH || (state == PC_RUN && !jump_en_i)) && !hold_i;
  assign top = adv && pc == {PC_W{1'b1}};
  assign inst_addr_o = pc;
  assign inst_valid_o = state != PC_HALT;
  assign halted_o = state == PC_HALT;
  assign flush_o = take || state == PC_FLUSH;
  // fetch address: redirect on a taken branch, else step unless stalled or at the top
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= PC_RESET;
    else if (take) pc <= target;
    else if (adv && !top) pc <= pc + 1'b1;
  // control FSM: branch-to-self and running off the end both stop the core
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= PC_RUN;
    else if (take) state <= jump_offset_i == '0 ? PC_HALT : (FLUSH_CYCLES > 1 ? PC_FLUSH : PC_RUN);
    else if (top) state <= PC_HALT;
    else if (state == PC_FLUSH && fcnt == 2'd1) state <= PC_RUN;
  // remaining registered flush cycles after the combinational one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fcnt <= '0;
    else if (take) fcnt <= 2'(FLUSH_CYCLES - 1);
    else if (state == PC_FLUSH && fcnt != '0) fcnt <= fcnt - 2'd1;
  sat_cnt8 u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (take),
    .cnt  (branch_cnt_o)
  );
endmodule
